// File: rtl/feedback_pulse_driver.sv
// rtl/feedback_pulse_driver.sv - blink/beep driver producing N equal ON phases separated by OFF phases
module feedback_pulse_driver #(
    parameter int CNTR_WIDTH = 20,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 trig_pulse,
    input  logic [CNT_WIDTH-1:0] trig_count,
    input  logic                 abort,
    output logic                 out_level,
    output logic                 busy,
    output logic                 done_pulse,
    output logic                 overrun_pulse
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    localparam logic [CNTR_WIDTH-1:0] CNTR_ONE = CNTR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  REM_ONE  = CNT_WIDTH'(1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNTR_WIDTH-1:0] r_cnt;
    logic [CNTR_WIDTH-1:0] w_cnt_nxt;
    logic [CNT_WIDTH-1:0]  r_rem;
    logic [CNT_WIDTH-1:0]  w_rem_nxt;
    logic                  r_out;
    logic                  w_out_nxt;
    logic                  r_busy;
    logic                  w_busy_nxt;
    logic                  r_done;
    logic                  w_done_nxt;
    logic                  r_ovr;
    logic                  w_ovr_nxt;
    logic                  w_phase_end;
    logic [CNT_WIDTH-1:0]  w_req_count;

    assign w_phase_end = (r_cnt == '1);
    // A zero-length request still gives one blink.
    assign w_req_count = (trig_count == '0) ? REM_ONE : trig_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_out   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rem   <= w_rem_nxt;
            r_out   <= w_out_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_ovr   <= w_ovr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rem_nxt   = r_rem;
        w_out_nxt   = r_out;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_ovr_nxt   = 1'b0;

        if (abort) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_rem_nxt   = '0;
            w_out_nxt   = 1'b0;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (trig_pulse) begin
                        w_state_nxt = S_ON;
                        w_cnt_nxt   = '0;
                        w_rem_nxt   = w_req_count;
                        w_out_nxt   = 1'b1;
                        w_busy_nxt  = 1'b1;
                    end
                end
                S_ON: begin
                    // Triggers are dropped even on the final edge of the request.
                    w_ovr_nxt = trig_pulse;
                    if (w_phase_end) begin
                        w_cnt_nxt = '0;
                        w_out_nxt = 1'b0;
                        if (r_rem <= REM_ONE) begin
                            w_state_nxt = S_IDLE;
                            w_rem_nxt   = '0;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = S_OFF;
                            w_rem_nxt   = r_rem - REM_ONE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNTR_ONE;
                    end
                end
                S_OFF: begin
                    w_ovr_nxt = trig_pulse;
                    if (w_phase_end) begin
                        w_state_nxt = S_ON;
                        w_cnt_nxt   = '0;
                        w_out_nxt   = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNTR_ONE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_rem_nxt   = '0;
                    w_out_nxt   = 1'b0;
                    w_busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    assign out_level     = r_out;
    assign busy          = r_busy;
    assign done_pulse    = r_done;
    assign overrun_pulse = r_ovr;

endmodule

// File: tb/tb_feedback_pulse_driver.sv
// tb/tb_feedback_pulse_driver.sv - directed bench for feedback_pulse_driver with 8-cycle phases
module tb_feedback_pulse_driver;

    logic       clk;
    logic       rst_n;
    logic       trig_pulse;
    logic [3:0] trig_count;
    logic       abort;
    logic       out_level;
    logic       busy;
    logic       done_pulse;
    logic       overrun_pulse;

    int checks;
    int failures;

    bit cap_out  [0:63];
    bit cap_busy [0:63];
    bit cap_done [0:63];
    bit cap_ovr  [0:63];

    feedback_pulse_driver #(
        .CNTR_WIDTH(3),
        .CNT_WIDTH (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trig_pulse   (trig_pulse),
        .trig_count   (trig_count),
        .abort        (abort),
        .out_level    (out_level),
        .busy         (busy),
        .done_pulse   (done_pulse),
        .overrun_pulse(overrun_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sample k reflects the edge at which trig (k==1 always) was seen.
    task automatic capture(input int len, input logic [3:0] tc, input int tk1, input int tk2, input int ak);
        for (int k = 1; k <= len; k++) begin
            trig_pulse = (k == 1) || (k == tk1) || (k == tk2);
            abort      = (k == ak);
            trig_count = tc;
            step();
            cap_out[k]  = out_level;
            cap_busy[k] = busy;
            cap_done[k] = done_pulse;
            cap_ovr[k]  = overrun_pulse;
        end
        trig_pulse = 1'b0;
        abort      = 1'b0;
    endtask

    function automatic bit exp_on(input int n, input int k);
        int span;
        span = (2 * n - 1) * 8;
        return (k >= 1) && (k <= span) && (((k - 1) / 8) % 2 == 0);
    endfunction

    function automatic bit exp_busy(input int n, input int k);
        return (k >= 1) && (k <= (2 * n - 1) * 8);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; trig_pulse = 1'b0; abort = 1'b0; trig_count = 4'd0;
        step(); step();
        checks++; if (out_level !== 1'b0)     begin failures++; $display("FAIL reset_out got=%b exp=0", out_level); end
        checks++; if (busy !== 1'b0)          begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done_pulse !== 1'b0)    begin failures++; $display("FAIL reset_done got=%b exp=0", done_pulse); end
        checks++; if (overrun_pulse !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b exp=0", overrun_pulse); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_pattern(input string name, input logic [3:0] tc, input int n);
        int len;
        len = (2 * n - 1) * 8 + 4;
        capture(len, tc, 0, 0, 0);
        for (int k = 1; k <= len; k++) begin
            checks++; if (cap_out[k] !== exp_on(n, k))
                begin failures++; $display("FAIL %s_out k=%0d got=%b exp=%b", name, k, cap_out[k], exp_on(n, k)); end
            checks++; if (cap_busy[k] !== exp_busy(n, k))
                begin failures++; $display("FAIL %s_busy k=%0d got=%b exp=%b", name, k, cap_busy[k], exp_busy(n, k)); end
            checks++; if (cap_done[k] !== (k == (2 * n - 1) * 8 + 1))
                begin failures++; $display("FAIL %s_done k=%0d got=%b", name, k, cap_done[k]); end
            checks++; if (cap_ovr[k] !== 1'b0)
                begin failures++; $display("FAIL %s_ovr k=%0d got=%b exp=0", name, k, cap_ovr[k]); end
        end
    endtask

    task automatic test_overrun();
        capture(28, 4'd2, 5, 25, 0);
        for (int k = 1; k <= 28; k++) begin
            checks++; if (cap_out[k] !== exp_on(2, k))
                begin failures++; $display("FAIL ovr_out k=%0d got=%b exp=%b", k, cap_out[k], exp_on(2, k)); end
            checks++; if (cap_busy[k] !== exp_busy(2, k))
                begin failures++; $display("FAIL ovr_busy k=%0d got=%b exp=%b", k, cap_busy[k], exp_busy(2, k)); end
            checks++; if (cap_done[k] !== (k == 25))
                begin failures++; $display("FAIL ovr_done k=%0d got=%b", k, cap_done[k]); end
            checks++; if (cap_ovr[k] !== ((k == 5) || (k == 25)))
                begin failures++; $display("FAIL ovr_pulse k=%0d got=%b", k, cap_ovr[k]); end
        end
    endtask

    task automatic test_abort();
        capture(20, 4'd3, 0, 0, 12);
        for (int k = 1; k <= 20; k++) begin
            checks++; if (cap_out[k] !== ((k < 12) && exp_on(3, k)))
                begin failures++; $display("FAIL abort_out k=%0d got=%b", k, cap_out[k]); end
            checks++; if (cap_busy[k] !== (k < 12))
                begin failures++; $display("FAIL abort_busy k=%0d got=%b exp=%b", k, cap_busy[k], (k < 12)); end
            checks++; if (cap_done[k] !== 1'b0)
                begin failures++; $display("FAIL abort_done k=%0d got=%b exp=0", k, cap_done[k]); end
            checks++; if (cap_ovr[k] !== 1'b0)
                begin failures++; $display("FAIL abort_ovr k=%0d got=%b exp=0", k, cap_ovr[k]); end
        end
    endtask

    task automatic test_abort_trig_idle();
        for (int k = 0; k < 4; k++) begin
            abort = 1'b1; trig_pulse = 1'b1; trig_count = 4'd2;
            step();
            checks++; if (busy !== 1'b0)          begin failures++; $display("FAIL abort_hold_busy k=%0d got=%b exp=0", k, busy); end
            checks++; if (out_level !== 1'b0)     begin failures++; $display("FAIL abort_hold_out k=%0d got=%b exp=0", k, out_level); end
            checks++; if (overrun_pulse !== 1'b0) begin failures++; $display("FAIL abort_hold_ovr k=%0d got=%b exp=0", k, overrun_pulse); end
        end
        abort = 1'b0; trig_pulse = 1'b0;
        step(); step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_release_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        trig_pulse = 1'b1; trig_count = 4'd1;
        step();
        trig_pulse = 1'b0;
        step(); step(); step();
        checks++; if (out_level !== 1'b1) begin failures++; $display("FAIL rstmid_pre_out got=%b exp=1", out_level); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_level !== 1'b0) begin failures++; $display("FAIL rstmid_async_out got=%b exp=0", out_level); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL rstmid_async_busy got=%b exp=0", busy); end
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL rstmid_idle_busy k=%0d got=%b exp=0", k, busy); end
            checks++; if (out_level !== 1'b0) begin failures++; $display("FAIL rstmid_idle_out k=%0d got=%b exp=0", k, out_level); end
            checks++; if (done_pulse !== 1'b0) begin failures++; $display("FAIL rstmid_idle_done k=%0d got=%b exp=0", k, done_pulse); end
        end
        // Second reset: the trigger arrives on the very first edge after release.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        capture(10, 4'd1, 0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            checks++; if (cap_out[k] !== exp_on(1, k))
                begin failures++; $display("FAIL rstmid_new_out k=%0d got=%b exp=%b", k, cap_out[k], exp_on(1, k)); end
            checks++; if (cap_done[k] !== (k == 9))
                begin failures++; $display("FAIL rstmid_new_done k=%0d got=%b", k, cap_done[k]); end
        end
    endtask

    task automatic test_back_to_back();
        bit e;
        capture(20, 4'd1, 10, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            e = ((k >= 1) && (k <= 8)) || ((k >= 10) && (k <= 17));
            checks++; if (cap_out[k] !== e)
                begin failures++; $display("FAIL b2b_out k=%0d got=%b exp=%b", k, cap_out[k], e); end
            checks++; if (cap_busy[k] !== e)
                begin failures++; $display("FAIL b2b_busy k=%0d got=%b exp=%b", k, cap_busy[k], e); end
            checks++; if (cap_done[k] !== ((k == 9) || (k == 18)))
                begin failures++; $display("FAIL b2b_done k=%0d got=%b", k, cap_done[k]); end
            checks++; if (cap_ovr[k] !== 1'b0)
                begin failures++; $display("FAIL b2b_ovr k=%0d got=%b exp=0", k, cap_ovr[k]); end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_pattern("single", 4'd1, 1);
        test_pattern("multi", 4'd3, 3);
        test_pattern("zero", 4'd0, 1);
        test_overrun();
        test_abort();
        test_abort_trig_idle();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
